epd_frame_gen: RTL and testbench
================================

Name: epd_frame_gen

Overview:
Ethernet frame stimulus generator that sits directly upstream of the packet-detector FSM. It drives the detector's byte-wide data/control stream. On a start handshake it emits one complete frame:
- 7×0x55 preamble, 0xD5 SFD
- 6-byte DST, 6-byte SRC, 2-byte type/length
- programmable-length incrementing payload
- a programmable inter-frame gap (IFG) of idle bytes (control=0, data=0x00)

It is used for self-checking detector benches and as a synthesizable traffic source.

Parameters:
MIN_IFG, 1, number of IFG idle bytes after each frame; legal range 1..15.
LEN_W, 11, width of payload_len; maximum payload is 2^LEN_W-1 bytes.

Ports:
clock  in  1  rising-edge clock, one byte per cycle
reset  in  1  synchronous, active-low reset
start  in  1  frame request; accepted when start=1 and ready=1 at a rising edge
ready  out  1  generator can accept start this cycle
dst_addr  in  48  destination address, sampled on accept; [47:40] sent first
src_addr  in  48  source address, sampled on accept; [47:40] sent first
type_length  in  16  sampled on accept; [15:8] sent first
payload_len  in  LEN_W  payload byte count, sampled on accept; 0 is legal
payload_seed  in  8  first payload byte, sampled on accept
data  out  8  byte stream to detector
control  out  1  1 = frame byte, 0 = idle/IFG byte
busy  out  1  1 whenever state != IDLE
frame_done  out  1  one-cycle pulse, see below
frame_count  out  4  frames completed modulo 16

Behaviour:
- Reset (reset=0 at rising edge):
  - Next cycle: state=IDLE, data=0x00, control=0, ready=1, busy=0, frame_done=0, frame_count=0.
  - Reset mid-frame aborts the frame immediately. No frame_done is issued and frame_count is not incremented.
- All outputs are registered.
- Accept:
  - At the accept edge, all input fields are latched; later input changes do not affect the frame in flight.
  - The first preamble byte (0x55, control=1) appears in the cycle immediately after the accept edge, so latency = 1 cycle.
- ready=1 in IDLE and in the final IFG cycle only. start with ready=0 is ignored, with no queuing.
- States and byte counts (control=1 in all except IDLE and IFG):
  - IDLE: data=0x00, control=0.
  - PRE: 7 cycles of 0x55.
  - SFD: 1 cycle of 0xD5.
  - DST: 6 cycles, bytes dst[47:40] .. dst[7:0].
  - SRC: 6 cycles, same ordering as DST.
  - TYPE: 2 cycles, type_length[15:8] then [7:0].
  - PAY: payload_len cycles; byte i = (payload_seed + i) mod 256, wrapping 0xFF→0x00.
  - IFG: MIN_IFG cycles, data=0x00, control=0.
- Transitions:
  - IDLE→PRE on accept.
  - TYPE→PAY if payload_len != 0; TYPE→IFG if payload_len = 0.
  - PAY→IFG after the last payload byte.
  - IFG→IDLE after MIN_IFG cycles, or IFG→PRE if start is accepted in the final IFG cycle (back-to-back).
- Frame length on the wire = 22 + payload_len cycles with control=1.
- Back-to-back frames with start held high: exactly MIN_IFG idle cycles between the last byte of one frame and the first preamble byte of the next.
- frame_done and frame_count:
  - frame_done pulses for exactly the first IFG cycle.
  - frame_count increments at the same edge that frame_done asserts, wrapping 15→0.
- Internal counters: byte-index counter wide enough for LEN_W; IFG counter 4 bits. No other storage beyond the latched fields.

Test Plan:
1. Reset low 2 cycles, then high, with start=0 → data=0x00, control=0, ready=1, busy=0, frame_count=0 held indefinitely.
2. Single frame, fields and payload as below → control=1 for exactly 72 cycles, then 1 idle cycle with frame_done=1; frame_count=1.
   - Inputs: dst=0x010203040506, src=0xFFFEFDFCFBFA, type=0x0800, payload_len=50, seed=0x55.
   - Expected stream: 55×7, D5, 01..06, FF..FA, 08, 00, 55,56,..,86.
3. payload_len=0 → frame ends after the type byte 0x00 (22 control=1 cycles); frame_done is asserted in the next cycle.
4. seed=0xFE, payload_len=4 → payload 0xFE, 0xFF, 0x00, 0x01 (wrap-around).
5. MIN_IFG=4, start held high for 3 frames → exactly 4 control=0 cycles between frames; start toggling while busy is ignored; frame_count=3.
6. reset=0 asserted on the 3rd DST byte → next cycle idle, frame_count=0, no frame_done. A subsequent start yields a clean full frame with frame_count=1.
7. 17 frames → frame_count wraps to 1.

Source files
------------

// File: rtl/epd_frame_gen.sv
// Byte-wide Ethernet frame generator: preamble, SFD, addresses, type, incrementing payload, IFG.
// All outputs are registered; state_dbg exposes the FSM state for checkers.
module epd_frame_gen #(
    parameter int MIN_IFG = 1,
    parameter int LEN_W   = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [47:0]      dst_addr,
    input  logic [47:0]      src_addr,
    input  logic [15:0]      type_length,
    input  logic [LEN_W-1:0] payload_len,
    input  logic [7:0]       payload_seed,
    output logic [7:0]       data,
    output logic             control,
    output logic             busy,
    output logic             frame_done,
    output logic [3:0]       frame_count,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_TYPE, S_PAY, S_IFG
    } state_t;

    localparam logic [3:0] IFG_LAST = 4'(MIN_IFG - 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [3:0]       ifg_q, ifg_d;
    logic [47:0]      dst_q, dst_d, src_q, src_d;
    logic [15:0]      type_q, type_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       seed_q, seed_d;
    logic [7:0]       data_q, data_d;
    logic             control_q, control_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic [3:0]       frame_count_q, frame_count_d;
    logic             accept;

    function automatic logic [7:0] addr_byte(input logic [47:0] a, input logic [2:0] i);
        case (i)
            3'd0:    addr_byte = a[47:40];
            3'd1:    addr_byte = a[39:32];
            3'd2:    addr_byte = a[31:24];
            3'd3:    addr_byte = a[23:16];
            3'd4:    addr_byte = a[15:8];
            default: addr_byte = a[7:0];
        endcase
    endfunction

    // Handshake: a request is taken when start=1 and ready=1 at a rising edge; start with ready=0 is dropped.
    always_comb begin
        accept = start && ready_q;
        state_d = state_q;
        idx_d   = idx_q;
        ifg_d   = ifg_q;
        dst_d   = dst_q;
        src_d   = src_q;
        type_d  = type_q;
        len_d   = len_q;
        seed_d  = seed_q;

        if (accept) begin
            dst_d  = dst_addr;
            src_d  = src_addr;
            type_d = type_length;
            len_d  = payload_len;
            seed_d = payload_seed;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_PRE;
                    idx_d   = '0;
                end
            end
            S_PRE: begin
                if (idx_q == LEN_W'(6)) begin
                    state_d = S_SFD;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            S_SFD: begin
                state_d = S_DST;
                idx_d   = '0;
            end
            S_DST: begin
                if (idx_q == LEN_W'(5)) begin
                    state_d = S_SRC;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            S_SRC: begin
                if (idx_q == LEN_W'(5)) begin
                    state_d = S_TYPE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            S_TYPE: begin
                if (idx_q == LEN_W'(1)) begin
                    state_d = (len_q != '0) ? S_PAY : S_IFG;
                    idx_d   = '0;
                    ifg_d   = '0;
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            S_PAY: begin
                if (idx_q + LEN_W'(1) == len_q) begin
                    state_d = S_IFG;
                    idx_d   = '0;
                    ifg_d   = '0;
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            S_IFG: begin
                if (ifg_q == IFG_LAST) begin
                    state_d = accept ? S_PRE : S_IDLE;
                    idx_d   = '0;
                    ifg_d   = '0;
                end else begin
                    ifg_d = ifg_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Output byte is derived from the state entered at this edge, keeping outputs registered.
        case (state_d)
            S_PRE:   data_d = 8'h55;
            S_SFD:   data_d = 8'hD5;
            S_DST:   data_d = addr_byte(dst_q, idx_d[2:0]);
            S_SRC:   data_d = addr_byte(src_q, idx_d[2:0]);
            S_TYPE:  data_d = idx_d[0] ? type_q[7:0] : type_q[15:8];
            S_PAY:   data_d = seed_q + 8'(idx_d);
            default: data_d = 8'h00;
        endcase

        control_d     = (state_d != S_IDLE) && (state_d != S_IFG);
        busy_d        = (state_d != S_IDLE);
        ready_d       = (state_d == S_IDLE) || ((state_d == S_IFG) && (ifg_d == IFG_LAST));
        frame_done_d  = (state_d == S_IFG) && (state_q != S_IFG);
        frame_count_d = frame_count_q + (frame_done_d ? 4'd1 : 4'd0);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            ifg_q         <= '0;
            dst_q         <= '0;
            src_q         <= '0;
            type_q        <= '0;
            len_q         <= '0;
            seed_q        <= '0;
            data_q        <= 8'h00;
            control_q     <= 1'b0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            ifg_q         <= ifg_d;
            dst_q         <= dst_d;
            src_q         <= src_d;
            type_q        <= type_d;
            len_q         <= len_d;
            seed_q        <= seed_d;
            data_q        <= data_d;
            control_q     <= control_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign ready       = ready_q;
    assign data        = data_q;
    assign control     = control_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_epd_frame_gen.sv
// Bench for epd_frame_gen: two instances (IFG of 1 and 4) checked every cycle against a queue-based frame model.
module tb_epd_frame_gen;
    localparam int LEN_W = 11;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset;
    logic             start;
    logic [47:0]      dst_addr;
    logic [47:0]      src_addr;
    logic [15:0]      type_length;
    logic [LEN_W-1:0] payload_len;
    logic [7:0]       payload_seed;

    logic       ready_w[2];
    logic [7:0] data_w[2];
    logic       control_w[2];
    logic       busy_w[2];
    logic       done_w[2];
    logic [3:0] cnt_w[2];
    logic [2:0] st_w[2];

    epd_frame_gen #(.MIN_IFG(1), .LEN_W(LEN_W)) dut0 (
        .clock(clock), .reset(reset), .start(start), .ready(ready_w[0]),
        .dst_addr(dst_addr), .src_addr(src_addr), .type_length(type_length),
        .payload_len(payload_len), .payload_seed(payload_seed),
        .data(data_w[0]), .control(control_w[0]), .busy(busy_w[0]),
        .frame_done(done_w[0]), .frame_count(cnt_w[0]), .state_dbg(st_w[0])
    );

    epd_frame_gen #(.MIN_IFG(4), .LEN_W(LEN_W)) dut4 (
        .clock(clock), .reset(reset), .start(start), .ready(ready_w[1]),
        .dst_addr(dst_addr), .src_addr(src_addr), .type_length(type_length),
        .payload_len(payload_len), .payload_seed(payload_seed),
        .data(data_w[1]), .control(control_w[1]), .busy(busy_w[1]),
        .frame_done(done_w[1]), .frame_count(cnt_w[1]), .state_dbg(st_w[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: each accepted request expands into the full list of wire bytes it produces.
    typedef struct packed {
        logic       ctrl;
        logic [7:0] data;
        logic       done;
        logic       busy;
    } item_t;

    localparam item_t IDLE_ITEM = '{ctrl: 1'b0, data: 8'h00, done: 1'b0, busy: 1'b0};

    item_t      mq[2][$];
    item_t      cur[2];
    logic [3:0] mcnt[2];
    bit         acc[2];
    int         acc_n[2];
    bit         chk_on = 1'b0;

    function automatic int ifg_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic item_t mk(input logic c, input logic [7:0] d, input logic dn);
        item_t it;
        it.ctrl = c;
        it.data = d;
        it.done = dn;
        it.busy = 1'b1;
        return it;
    endfunction

    task automatic push_frame(input int k);
        for (int i = 0; i < 7; i++) mq[k].push_back(mk(1'b1, 8'h55, 1'b0));
        mq[k].push_back(mk(1'b1, 8'hD5, 1'b0));
        for (int i = 0; i < 6; i++) mq[k].push_back(mk(1'b1, 8'(dst_addr >> (8 * (5 - i))), 1'b0));
        for (int i = 0; i < 6; i++) mq[k].push_back(mk(1'b1, 8'(src_addr >> (8 * (5 - i))), 1'b0));
        mq[k].push_back(mk(1'b1, type_length[15:8], 1'b0));
        mq[k].push_back(mk(1'b1, type_length[7:0], 1'b0));
        for (int i = 0; i < int'(payload_len); i++)
            mq[k].push_back(mk(1'b1, 8'((int'(payload_seed) + i) % 256), 1'b0));
        for (int i = 0; i < ifg_of(k); i++) mq[k].push_back(mk(1'b0, 8'h00, i == 0));
    endtask

    always @(posedge clock) begin
        item_t it;
        bit    a;
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                mq[k].delete();
                cur[k]   <= IDLE_ITEM;
                mcnt[k]  <= 4'd0;
                acc[k]   <= 1'b0;
            end else begin
                a = start && (mq[k].size() == 0);
                if (a) push_frame(k);
                it = (mq[k].size() > 0) ? mq[k].pop_front() : IDLE_ITEM;
                cur[k]  <= it;
                mcnt[k] <= mcnt[k] + (it.done ? 4'd1 : 4'd0);
                acc[k]  <= a;
                if (a) acc_n[k] <= acc_n[k] + 1;
            end
        end
    end

    // Every-cycle scoreboard: {ready,busy,control,frame_done,frame_count,data}.
    always @(negedge clock) begin
        logic [15:0] got, exp;
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                got = {ready_w[k], busy_w[k], control_w[k], done_w[k], cnt_w[k], data_w[k]};
                exp = {mq[k].size() == 0, cur[k].busy, cur[k].ctrl, cur[k].done, mcnt[k], cur[k].data};
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL cycle_out dut%0d t=%0t got=%h exp=%h", k, $time, got, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic randomize_fields();
        dst_addr     = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        src_addr     = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        type_length  = 16'($urandom);
        payload_len  = LEN_W'($urandom_range(0, 40));
        payload_seed = 8'($urandom);
    endtask

    // Requests a frame and returns at the negedge of its first preamble byte (instance 0).
    task automatic send(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                        input logic [LEN_W-1:0] l, input logic [7:0] sd);
        bit ok;
        @(negedge clock);
        dst_addr = d; src_addr = s; type_length = t; payload_len = l; payload_seed = sd;
        start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clock);
            #1;
            ok = acc[0];
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_timeout t=%0t", $time);
        end
        @(negedge clock);
        start = 1'b0;
        randomize_fields();
    endtask

    // Counts control=1 cycles of instance 0 from the current cycle until the first idle byte.
    task automatic measure(output int n, output logic [7:0] last);
        n = 0;
        last = 8'h00;
        for (int i = 0; i < 5000 && control_w[0]; i++) begin
            n++;
            last = data_w[0];
            @(negedge clock);
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (mq[0].size() == 0 && mq[1].size() == 0 && !cur[0].busy && !cur[1].busy) return;
        end
        bad++;
        total++;
        $display("FAIL settle_timeout t=%0t", $time);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        repeat (cycles) @(negedge clock);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [47:0]      dst;
        logic [47:0]      src;
        logic [15:0]      typ;
        logic [LEN_W-1:0] len;
        logic [7:0]       seed;
        int               exp_n;
        logic [7:0]       exp_last;
        logic [3:0]       exp_cnt;
    } vec_t;

    vec_t vecs[5];
    bit   ctrl_hist[$];

    initial begin
        int         n;
        logic [7:0] last;
        int         runs1[$];
        int         runs0[$];
        int         run;
        bit         prev;
        bit         seen1;

        vecs[0] = '{48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 11'd50,  8'h55, 72,  8'h86, 4'd1};
        vecs[1] = '{48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, 11'd0,   8'h12, 22,  8'h00, 4'd2};
        vecs[2] = '{48'h000000000001, 48'h800000000000, 16'h86DD, 11'd4,   8'hFE, 26,  8'h01, 4'd3};
        vecs[3] = '{48'hFFFFFFFFFFFF, 48'h000000000000, 16'h0001, 11'd1,   8'h10, 23,  8'h10, 4'd4};
        vecs[4] = '{48'h123456789ABC, 48'hDEF012345678, 16'h05DC, 11'd256, 8'h00, 278, 8'hFF, 4'd5};

        reset = 1'b0;
        start = 1'b0;
        acc_n[0] = 0;
        acc_n[1] = 0;
        randomize_fields();
        @(posedge clock);
        @(negedge clock);
        chk_on = 1'b1;
        @(negedge clock);
        reset = 1'b1;

        // Reset state holds while start stays low.
        repeat (6) @(negedge clock);
        chk("rst_data", 32'(data_w[0]), 32'h00);
        chk("rst_ctrl", 32'(control_w[0]), 32'h0);
        chk("rst_ready", 32'(ready_w[0]), 32'h1);
        chk("rst_busy", 32'(busy_w[0]), 32'h0);
        chk("rst_cnt", 32'(cnt_w[0]), 32'h0);

        for (int v = 0; v < 5; v++) begin
            send(vecs[v].dst, vecs[v].src, vecs[v].typ, vecs[v].len, vecs[v].seed);
            chk($sformatf("v%0d_first", v), 32'(data_w[0]), 32'h55);
            measure(n, last);
            chk($sformatf("v%0d_len", v), 32'(n), 32'(vecs[v].exp_n));
            chk($sformatf("v%0d_last", v), 32'(last), 32'(vecs[v].exp_last));
            chk($sformatf("v%0d_done", v), 32'(done_w[0]), 32'h1);
            chk($sformatf("v%0d_cnt", v), 32'(cnt_w[0]), 32'(vecs[v].exp_cnt));
            settle();
        end

        // Back-to-back with start held: instance with IFG=4 must show exactly 4 idles between frames.
        do_reset(2);
        repeat (3) @(negedge clock);
        acc_n[1] = 0;
        dst_addr = 48'h0A0B0C0D0E0F; src_addr = 48'h101112131415;
        type_length = 16'h0800; payload_len = 11'd3; payload_seed = 8'h40;
        start = 1'b1;
        ctrl_hist.delete();
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            ctrl_hist.push_back(control_w[1]);
            if (acc_n[1] >= 3) start = 1'b0;
            if (acc_n[1] >= 3 && mq[1].size() == 0 && !cur[1].busy) break;
        end
        start = 1'b0;
        prev = 1'b0; run = 0; seen1 = 1'b0;
        foreach (ctrl_hist[i]) begin
            if (ctrl_hist[i] != prev && i > 0) begin
                if (prev) runs1.push_back(run);
                else if (seen1) runs0.push_back(run);
                run = 0;
            end
            if (ctrl_hist[i]) seen1 = 1'b1;
            run++;
            prev = ctrl_hist[i];
        end
        if (prev) runs1.push_back(run);
        chk("b2b_frames", 32'(runs1.size()), 32'd3);
        chk("b2b_gaps", 32'(runs0.size() >= 2 ? 2 : runs0.size()), 32'd2);
        if (runs0.size() >= 2) begin
            chk("b2b_gap0", 32'(runs0[0]), 32'd4);
            chk("b2b_gap1", 32'(runs0[1]), 32'd4);
        end
        if (runs1.size() >= 1) chk("b2b_flen", 32'(runs1[0]), 32'd25);
        chk("b2b_cnt", 32'(cnt_w[1]), 32'd3);
        settle();

        // Reset on the third destination byte aborts with no completion.
        send(48'hC0C1C2C3C4C5, 48'hD0D1D2D3D4D5, 16'h0806, 11'd10, 8'h00);
        repeat (10) @(negedge clock);
        chk("abort_byte", 32'(data_w[0]), 32'hC2);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("abort_ctrl", 32'(control_w[0]), 32'h0);
        chk("abort_done", 32'(done_w[0]), 32'h0);
        chk("abort_cnt", 32'(cnt_w[0]), 32'h0);
        chk("abort_data", 32'(data_w[0]), 32'h00);
        send(48'hC0C1C2C3C4C5, 48'hD0D1D2D3D4D5, 16'h0806, 11'd10, 8'h00);
        measure(n, last);
        chk("post_abort_len", 32'(n), 32'd32);
        chk("post_abort_cnt", 32'(cnt_w[0]), 32'd1);
        settle();

        // 16 more frames: 17 in total since reset wraps the count to 1.
        for (int f = 0; f < 16; f++) begin
            send(48'h1, 48'h2, 16'h3, LEN_W'(f % 3), 8'(f));
            measure(n, last);
            chk($sformatf("wrap_len%0d", f), 32'(n), 32'(22 + f % 3));
        end
        chk("wrap_cnt", 32'(cnt_w[0]), 32'd1);
        settle();

        // Random traffic: start toggles freely, fields change every cycle, rare resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            start = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 599) != 0);
            randomize_fields();
        end
        @(negedge clock);
        start = 1'b0;
        reset = 1'b1;
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
